// File: rtl/cache_data_wb.sv
`default_nettype none
// ============================================================================
// Module      : cache_data_wb
// Description : Writeback data store for one cache bank. Per-byte dirty masks
//               live in flops, line data in a single-port synchronous RAM.
//               Dirty victims from fills or from the flush walker go to a
//               one-entry eviction buffer with a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_data_wb #(
  parameter int CACHE_SIZE = 1024,
  parameter int LINE_SIZE  = 16,
  parameter int NUM_BANKS  = 1,
  parameter int NUM_WAYS   = 2,
  parameter int WORD_SIZE  = 4,
  localparam int LINES  = CACHE_SIZE / LINE_SIZE / NUM_BANKS / NUM_WAYS,
  localparam int WPL    = LINE_SIZE / WORD_SIZE,
  localparam int LINE_W = (LINES > 1) ? $clog2(LINES) : 1,
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  localparam int WSEL_W = (WPL > 1) ? $clog2(WPL) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [LINE_W-1:0]        req_line,
  input  logic [NUM_WAYS-1:0]      req_way,
  input  logic [WSEL_W-1:0]        req_wsel,
  input  logic [WORD_SIZE-1:0]     req_byteen,
  input  logic [8*WORD_SIZE-1:0]   req_wdata,
  input  logic [8*LINE_SIZE-1:0]   req_fdata,
  output logic                     rsp_valid,
  output logic [8*WORD_SIZE-1:0]   rsp_data,
  output logic                     evict_valid,
  input  logic                     evict_ready,
  output logic [LINE_W-1:0]        evict_line,
  output logic [WAY_W-1:0]         evict_way,
  output logic [8*LINE_SIZE-1:0]   evict_data,
  output logic [LINE_SIZE-1:0]     evict_byteen,
  input  logic                     flush_req,
  output logic                     flush_busy,
  output logic                     flush_done
);

  localparam int ENTRIES = LINES * NUM_WAYS;
  localparam int ADDR_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int LBITS   = 8 * LINE_SIZE;
  localparam int WBITS   = 8 * WORD_SIZE;

  localparam logic [1:0]      OP_READ  = 2'b00;
  localparam logic [1:0]      OP_WRITE = 2'b01;
  localparam logic [1:0]      OP_FILL  = 2'b10;
  localparam logic [ADDR_W:0] SCAN_END = (ADDR_W + 1)'(ENTRIES);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL_CAP = 3'd1,
    FL_SCAN  = 3'd2,
    FL_RD    = 3'd3,
    FL_CAP   = 3'd4,
    FL_WAIT  = 3'd5
  } state_t;

  function automatic logic [WAY_W-1:0] onehot_idx(input logic [NUM_WAYS-1:0] oh);
    logic [WAY_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (oh[i]) idx = idx | WAY_W'(i);
    end
    return idx;
  endfunction

  state_t                r_state;
  logic [LINE_SIZE-1:0]  r_dirty [ENTRIES];
  logic [LBITS-1:0]      r_mem   [ENTRIES];
  logic [LBITS-1:0]      r_ram_q;

  logic [ADDR_W-1:0]     r_fill_addr;
  logic [LINE_W-1:0]     r_fill_line;
  logic [WAY_W-1:0]      r_fill_way;
  logic [LINE_SIZE-1:0]  r_fill_mask;
  logic [LBITS-1:0]      r_fill_data;

  logic [ADDR_W:0]       r_scan;
  logic                  r_rsp_valid;
  logic [WSEL_W-1:0]     r_rsp_wsel;
  logic [WBITS-1:0]      r_rsp_hold;

  logic                  r_evict_valid;
  logic [LINE_W-1:0]     r_evict_line;
  logic [WAY_W-1:0]      r_evict_way;
  logic [LBITS-1:0]      r_evict_data;
  logic [LINE_SIZE-1:0]  r_evict_byteen;
  logic                  r_flush_busy;
  logic                  r_flush_done;

  logic [WAY_W-1:0]      w_way_idx;
  logic [ADDR_W-1:0]     w_req_addr;
  logic                  w_req_dirty;
  logic                  w_accept;
  logic [LINE_SIZE-1:0]  w_req_wmask;
  logic [ADDR_W-1:0]     w_scan_addr;
  logic                  w_scan_dirty;
  logic [WBITS-1:0]      w_rsp_word;

  logic                  w_ram_rd;
  logic [LINE_SIZE-1:0]  w_ram_wmask;
  logic [ADDR_W-1:0]     w_ram_addr;
  logic [LBITS-1:0]      w_ram_wdata;

  assign w_way_idx    = onehot_idx(req_way);
  assign w_req_addr   = ADDR_W'(int'(req_line) * NUM_WAYS + int'(w_way_idx));
  assign w_req_dirty  = |r_dirty[w_req_addr];
  assign w_req_wmask  = LINE_SIZE'(req_byteen) << (int'(req_wsel) * WORD_SIZE);
  assign w_scan_addr  = r_scan[ADDR_W-1:0];
  assign w_scan_dirty = |r_dirty[w_scan_addr];

  // A dirty fill needs the eviction buffer; everything else may bypass it.
  assign req_ready = (r_state == IDLE) &
                     ~(r_evict_valid & (req_op == OP_FILL) & w_req_dirty);
  assign w_accept  = req_valid & req_ready;

  // The RAM output register only changes on reads, so the selected word is
  // live during the response pulse and a hold copy covers later cycles.
  assign w_rsp_word = r_ram_q[int'(r_rsp_wsel) * WBITS +: WBITS];
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_valid ? w_rsp_word : r_rsp_hold;

  assign evict_valid  = r_evict_valid;
  assign evict_line   = r_evict_line;
  assign evict_way    = r_evict_way;
  assign evict_data   = r_evict_data;
  assign evict_byteen = r_evict_byteen;
  assign flush_busy   = r_flush_busy;
  assign flush_done   = r_flush_done;

  // Single RAM port arbitration: one read or one byte-masked write per cycle.
  always_comb begin
    w_ram_rd    = 1'b0;
    w_ram_wmask = '0;
    w_ram_addr  = w_req_addr;
    w_ram_wdata = {WPL{req_wdata}};
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          case (req_op)
            OP_READ:  w_ram_rd = 1'b1;
            OP_WRITE: w_ram_wmask = w_req_wmask;
            OP_FILL: begin
              if (w_req_dirty) begin
                w_ram_rd = 1'b1;
              end else begin
                w_ram_wmask = '1;
                w_ram_wdata = req_fdata;
              end
            end
            default: ;
          endcase
        end
      end
      FILL_CAP: begin
        w_ram_addr  = r_fill_addr;
        w_ram_wmask = '1;
        w_ram_wdata = r_fill_data;
      end
      FL_RD: begin
        w_ram_addr = w_scan_addr;
        w_ram_rd   = 1'b1;
      end
      default: ;
    endcase
  end

  // Line storage with per-byte write enables; contents survive reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < LINE_SIZE; b++) begin
      if (w_ram_wmask[b]) r_mem[w_ram_addr][8*b +: 8] <= w_ram_wdata[8*b +: 8];
    end
  end

  // Registered RAM read data, loaded only by read accesses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ram_q <= '0;
    end else if (w_ram_rd) begin
      r_ram_q <= r_mem[w_ram_addr];
    end
  end

  // Control FSM: request handling, dirty tracking, eviction buffer, flush walk.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      for (int e = 0; e < ENTRIES; e++) r_dirty[e] <= '0;
      r_fill_addr    <= '0;
      r_fill_line    <= '0;
      r_fill_way     <= '0;
      r_fill_mask    <= '0;
      r_fill_data    <= '0;
      r_scan         <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_wsel     <= '0;
      r_rsp_hold     <= '0;
      r_evict_valid  <= 1'b0;
      r_evict_line   <= '0;
      r_evict_way    <= '0;
      r_evict_data   <= '0;
      r_evict_byteen <= '0;
      r_flush_busy   <= 1'b0;
      r_flush_done   <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      r_rsp_valid  <= 1'b0;
      if (r_rsp_valid) r_rsp_hold <= w_rsp_word;

      // Captures only happen into an empty buffer, so they never race a drain.
      if (r_evict_valid && evict_ready) begin
        r_evict_valid  <= 1'b0;
        r_evict_line   <= '0;
        r_evict_way    <= '0;
        r_evict_data   <= '0;
        r_evict_byteen <= '0;
      end

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            case (req_op)
              OP_READ: begin
                r_rsp_valid <= 1'b1;
                r_rsp_wsel  <= req_wsel;
              end
              OP_WRITE: r_dirty[w_req_addr] <= r_dirty[w_req_addr] | w_req_wmask;
              OP_FILL: begin
                if (w_req_dirty) begin
                  r_fill_addr <= w_req_addr;
                  r_fill_line <= req_line;
                  r_fill_way  <= w_way_idx;
                  r_fill_mask <= r_dirty[w_req_addr];
                  r_fill_data <= req_fdata;
                  r_state     <= FILL_CAP;
                end
              end
              default: ;
            endcase
          end else if (flush_req) begin
            r_state      <= FL_SCAN;
            r_flush_busy <= 1'b1;
            r_scan       <= '0;
          end
        end
        FILL_CAP: begin
          r_evict_valid        <= 1'b1;
          r_evict_line         <= r_fill_line;
          r_evict_way          <= r_fill_way;
          r_evict_data         <= r_ram_q;
          r_evict_byteen       <= r_fill_mask;
          r_dirty[r_fill_addr] <= '0;
          r_state              <= IDLE;
        end
        FL_SCAN: begin
          if (r_scan == SCAN_END) begin
            if (!r_evict_valid) begin
              r_flush_done <= 1'b1;
              r_flush_busy <= 1'b0;
              r_state      <= IDLE;
            end
          end else if (w_scan_dirty) begin
            if (!r_evict_valid) r_state <= FL_RD;
          end else begin
            r_scan <= r_scan + (ADDR_W + 1)'(1);
          end
        end
        FL_RD: r_state <= FL_CAP;
        FL_CAP: begin
          r_evict_valid        <= 1'b1;
          r_evict_line         <= LINE_W'(int'(w_scan_addr) / NUM_WAYS);
          r_evict_way          <= WAY_W'(int'(w_scan_addr) % NUM_WAYS);
          r_evict_data         <= r_ram_q;
          r_evict_byteen       <= r_dirty[w_scan_addr];
          r_dirty[w_scan_addr] <= '0;
          r_state              <= FL_WAIT;
        end
        FL_WAIT: begin
          if (!r_evict_valid) begin
            r_scan  <= r_scan + (ADDR_W + 1)'(1);
            r_state <= FL_SCAN;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_data_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_data_wb
// Description : Self-checking bench for cache_data_wb: a byte-array model of
//               the bank with dirty masks and an expected-eviction queue,
//               directed scenarios, then randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_data_wb;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_op = 2'b00;
  logic [4:0]   req_line = '0;
  logic [1:0]   req_way = 2'b01;
  logic [1:0]   req_wsel = '0;
  logic [3:0]   req_byteen = '0;
  logic [31:0]  req_wdata = '0;
  logic [127:0] req_fdata = '0;
  logic         rsp_valid;
  logic [31:0]  rsp_data;
  logic         evict_valid;
  logic         evict_ready = 1'b1;
  logic [4:0]   evict_line;
  logic [0:0]   evict_way;
  logic [127:0] evict_data;
  logic [15:0]  evict_byteen;
  logic         flush_req = 1'b0;
  logic         flush_busy;
  logic         flush_done;

  cache_data_wb dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_line(req_line), .req_way(req_way), .req_wsel(req_wsel),
    .req_byteen(req_byteen), .req_wdata(req_wdata), .req_fdata(req_fdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .evict_valid(evict_valid), .evict_ready(evict_ready),
    .evict_line(evict_line), .evict_way(evict_way), .evict_data(evict_data),
    .evict_byteen(evict_byteen),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event", nm);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0]   line;
    logic         way;
    logic [127:0] data;
    logic [15:0]  mask;
  } ev_t;

  logic [127:0] mem_m   [64];
  logic [15:0]  dirty_m [64];
  ev_t          exp_q [$];
  int           ev_log [$];
  bit           started = 0;
  bit           pend_rsp = 0;
  logic [31:0]  pend_data = '0;
  logic [31:0]  last_rsp = '0;
  bit           fillcap = 0;
  bit           prev_busy = 0;
  bit           prev_hold = 0;
  ev_t          prev_ev;
  int           me;
  ev_t          nev;
  logic         exp_rdy;

  // One compare process: outputs against the model, then apply this cycle's
  // accepted request to the model (it takes effect at the coming edge).
  always @(negedge clk) begin
    if (reset) begin
      started   = 1;
      for (int e = 0; e < 64; e++) dirty_m[e] = '0;
      exp_q.delete();
      pend_rsp  = 0;
      last_rsp  = '0;
      fillcap   = 0;
      prev_busy = 0;
      prev_hold = 0;
    end else if (started) begin
      chk("rsp_valid", rsp_valid, pend_rsp);
      if (pend_rsp) begin
        chk("rsp_data", rsp_data, pend_data);
        last_rsp = pend_data;
      end else begin
        chk("rsp_hold", rsp_data, last_rsp);
      end
      pend_rsp = 0;

      if (prev_hold) begin
        chk("evict_hold_valid", evict_valid, 1'b1);
        chk("evict_hold_fields", {evict_line, evict_way, evict_data, evict_byteen}, prev_ev);
      end

      if (flush_busy && !prev_busy) begin
        for (int e = 0; e < 64; e++) begin
          if (dirty_m[e] != 0) begin
            nev.line = 5'(e / 2); nev.way = e[0]; nev.data = mem_m[e]; nev.mask = dirty_m[e];
            exp_q.push_back(nev);
            dirty_m[e] = '0;
          end
        end
      end
      chk("flush_done_pulse", flush_done, prev_busy && !flush_busy);
      if (flush_done) chk("flush_done_drained", exp_q.size(), 0);
      prev_busy = flush_busy;

      exp_rdy = !flush_busy && !fillcap &&
                !(evict_valid && req_op == 2'b10 && dirty_m[req_line * 2 + (req_way[1] ? 1 : 0)] != 0);
      chk("req_ready", req_ready, exp_rdy);
      fillcap = 0;

      if (evict_valid) begin
        if (exp_q.size() == 0) begin
          chk("evict_unexpected", evict_valid, 1'b0);
        end else begin
          chk("evict_fields", {evict_line, evict_way, evict_data, evict_byteen}, exp_q[0]);
          if (evict_ready) begin
            ev_log.push_back(exp_q[0].line * 2 + exp_q[0].way);
            void'(exp_q.pop_front());
          end
        end
      end
      prev_hold = evict_valid && !evict_ready;
      prev_ev   = {evict_line, evict_way, evict_data, evict_byteen};

      if (req_valid && req_ready) begin
        chk("req_way_onehot", $onehot(req_way), 1'b1);
        me = req_line * 2 + (req_way[1] ? 1 : 0);
        case (req_op)
          2'b00: begin
            pend_rsp  = 1;
            pend_data = mem_m[me][req_wsel * 32 +: 32];
          end
          2'b01: begin
            for (int b = 0; b < 4; b++) begin
              if (req_byteen[b]) begin
                mem_m[me][(req_wsel * 4 + b) * 8 +: 8] = req_wdata[b * 8 +: 8];
                dirty_m[me][req_wsel * 4 + b] = 1'b1;
              end
            end
          end
          2'b10: begin
            if (dirty_m[me] != 0) begin
              nev.line = req_line; nev.way = req_way[1]; nev.data = mem_m[me]; nev.mask = dirty_m[me];
              exp_q.push_back(nev);
              fillcap = 1;
            end
            mem_m[me]   = req_fdata;
            dirty_m[me] = '0;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; returns just after the edge that accepted.
  task automatic send(input logic [1:0] op, input int line, input int way, input int wsel,
                      input logic [3:0] be, input logic [31:0] wd, input logic [127:0] fd);
    bit ok = 0;
    req_op = op; req_line = 5'(line); req_way = (way != 0) ? 2'b10 : 2'b01;
    req_wsel = 2'(wsel); req_byteen = be; req_wdata = wd; req_fdata = fd;
    req_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    cyc();
    req_valid = 1'b0;
    if (!ok) timeout("send_accept");
  endtask

  task automatic do_flush(output int nevict);
    int n0;
    bit got;
    n0 = ev_log.size();
    got = 0;
    flush_req = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (flush_busy) begin got = 1; break; end
    end
    if (!got) timeout("flush_start");
    cyc();
    flush_req = 1'b0;
    got = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (flush_done) begin got = 1; break; end
    end
    if (!got) timeout("flush_done");
    nevict = ev_log.size() - n0;
    cyc();
  endtask

  task automatic wait_quiet();
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!flush_busy && !evict_valid) begin ok = 1; break; end
    end
    if (!ok) timeout("drain");
    cyc();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    logic [127:0] fd;

    repeat (3) cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_evict_valid", evict_valid, 1'b0);
    chk("reset_flush_busy", flush_busy, 1'b0);
    chk("reset_flush_done", flush_done, 1'b0);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_data", rsp_data, 32'h0);
    chk("reset_req_ready", req_ready, 1'b1);
    cyc();

    // Known contents: byte b of entry e (= line*2+way) holds (e*16+b) mod 256.
    for (int e = 0; e < 64; e++) begin
      for (int b = 0; b < 16; b++) fd[b * 8 +: 8] = 8'((e * 16 + b) & 255);
      send(2'b10, e / 2, e % 2, 0, 4'h0, 32'h0, fd);
    end

    // Read line 3 way 0: response one cycle after accept.
    send(2'b00, 3, 0, 0, 4'h0, 32'h0, '0);
    @(negedge clk);
    chk("read_l3_valid", rsp_valid, 1'b1);
    chk("read_l3_data", rsp_data, 32'h63626160);
    chk("read_l3_no_evict", evict_valid, 1'b0);
    @(negedge clk);
    chk("read_l3_pulse_end", rsp_valid, 1'b0);
    cyc();

    // Byte-masked write then back-to-back read.
    send(2'b01, 5, 1, 2, 4'b0011, 32'hAABBCCDD, '0);
    send(2'b00, 5, 1, 2, 4'h0, 32'h0, '0);
    @(negedge clk);
    chk("write_readback", rsp_data, 32'hBBBACCDD);
    cyc();

    // Dirty fill: victim appears two cycles after accept.
    send(2'b10, 5, 1, 0, 4'h0, 32'h0, 128'hFFEEDDCC_BBAA9988_77665544_33221100);
    @(negedge clk);
    chk("dfill_evict_early", evict_valid, 1'b0);
    @(negedge clk);
    chk("dfill_evict_valid", evict_valid, 1'b1);
    chk("dfill_evict_line", evict_line, 5'd5);
    chk("dfill_evict_way", evict_way, 1'b1);
    chk("dfill_evict_byteen", evict_byteen, 16'h0300);
    chk("dfill_evict_word2", evict_data[95:64], 32'hBBBACCDD);
    cyc();
    send(2'b00, 5, 1, 2, 4'h0, 32'h0, '0);
    @(negedge clk);
    chk("dfill_read_new", rsp_data, 32'hBBAA9988);
    cyc();

    // Held eviction buffer blocks a second dirty fill but not a clean one.
    evict_ready = 1'b0;
    send(2'b01, 7, 0, 0, 4'hF, 32'h12345678, '0);
    send(2'b10, 7, 0, 0, 4'h0, 32'h0, {4{32'h5A5A0000}});
    send(2'b01, 8, 1, 1, 4'h4, 32'h00990000, '0);
    req_op = 2'b10; req_line = 5'd8; req_way = 2'b10; req_fdata = {4{32'h0BADF00D}};
    req_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("held_dfill_blocked", req_ready, 1'b0);
    end
    cyc();
    req_line = 5'd9; req_way = 2'b01; req_fdata = {4{32'hC1EA0F11}};
    @(negedge clk);
    chk("held_clean_fill_ready", req_ready, 1'b1);
    cyc();
    req_line = 5'd8; req_way = 2'b10; req_fdata = {4{32'h0BADF00D}};
    repeat (2) begin
      @(negedge clk);
      chk("held_dfill_blocked2", req_ready, 1'b0);
    end
    cyc();
    evict_ready = 1'b1;
    begin
      bit ok = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (req_ready) begin ok = 1; break; end
      end
      if (!ok) timeout("held_dfill_release");
    end
    cyc();
    req_valid = 1'b0;
    wait_quiet();

    // Flush with two dirty entries at the extremes.
    send(2'b01, 0, 0, 0, 4'h1, 32'h000000EE, '0);
    send(2'b01, 31, 1, 3, 4'h8, 32'h77000000, '0);
    base = ev_log.size();
    do_flush(n);
    chk("flush_count", n, 2);
    if (ev_log.size() >= base + 2) begin
      chk("flush_first", ev_log[base], 0);
      chk("flush_second", ev_log[base + 1], 63);
    end
    do_flush(n);
    chk("flush_again_count", n, 0);

    // Reset while the walker waits for a held eviction to drain.
    send(2'b01, 2, 0, 1, 4'h3, 32'h0000BEEF, '0);
    send(2'b01, 4, 1, 0, 4'hF, 32'hCAFEF00D, '0);
    evict_ready = 1'b0;
    flush_req = 1'b1;
    begin
      bit ok = 0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (evict_valid) begin ok = 1; break; end
      end
      if (!ok) timeout("flwait_evict");
    end
    cyc();
    flush_req = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("flreset_evict_valid", evict_valid, 1'b0);
    chk("flreset_flush_busy", flush_busy, 1'b0);
    cyc();
    evict_ready = 1'b1;
    do_flush(n);
    chk("flreset_flush_count", n, 0);

    // Randomized traffic on a few lines to force collisions.
    for (int c = 0; c < 3000; c++) begin
      req_valid   = ($urandom % 4) != 0;
      req_op      = 2'($urandom % 4);
      req_line    = 5'($urandom % 4);
      req_way     = ($urandom % 2) ? 2'b10 : 2'b01;
      req_wsel    = 2'($urandom % 4);
      req_byteen  = 4'($urandom % 16);
      req_wdata   = $urandom;
      req_fdata   = {$urandom, $urandom, $urandom, $urandom};
      evict_ready = ($urandom % 3) != 0;
      flush_req   = ($urandom % 60) == 0;
      cyc();
    end
    req_valid = 1'b0;
    flush_req = 1'b0;
    evict_ready = 1'b1;
    wait_quiet();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_data_wb.md
Name: cache_data_wb

Overview:
Writeback-capable data store for one cache bank, the next generation of the bank data array. It tracks per-byte dirty masks for every line and way in flops, and holds line data in a single-port synchronous RAM. Dirty victims, displaced by fills or walked out by an explicit flush sequencer, go to a one-entry eviction buffer with a valid/ready handshake toward the memory-request path.

Parameters:
CACHE_SIZE, 1024, bank-total cache bytes
LINE_SIZE, 16, bytes per line
NUM_BANKS, 1, banks (LINES = CACHE_SIZE/LINE_SIZE/NUM_BANKS/NUM_WAYS)
NUM_WAYS, 2, associativity (>=1)
WORD_SIZE, 4, bytes per word (WPL = LINE_SIZE/WORD_SIZE)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_op  in  2  00 read, 01 write, 10 fill, 11 reserved (ignored, accepted)
req_line  in  log2(LINES)  line index
req_way  in  NUM_WAYS  one-hot way select
req_wsel  in  max(1,log2(WPL))  word select
req_byteen  in  WORD_SIZE  write byte enables
req_wdata  in  8*WORD_SIZE  write word
req_fdata  in  8*LINE_SIZE  fill line
rsp_valid  out  1  read data valid pulse
rsp_data  out  8*WORD_SIZE  read word
evict_valid  out  1  eviction buffer occupied
evict_ready  in  1  downstream accepts eviction
evict_line  out  log2(LINES)  victim line index
evict_way  out  log2(NUM_WAYS)  victim way index
evict_data  out  8*LINE_SIZE  victim line data
evict_byteen  out  LINE_SIZE  victim dirty mask
flush_req  in  1  start full-cache flush (level, sampled in IDLE)
flush_busy  out  1  flush in progress
flush_done  out  1  one-cycle pulse at flush completion

Behaviour:
- Reset: all dirty masks 0, state IDLE, all outputs 0; RAM contents not cleared. Reset mid-flush or mid-fill aborts the operation and drops any pending eviction.
- FSM states: IDLE, FILL_CAP, FL_SCAN, FL_RD, FL_CAP, FL_WAIT.
- req_ready = IDLE & ~(evict_valid & op==fill & dirty[line][way]!=0). Reads, writes and clean fills proceed while the eviction buffer is occupied.
- Read: the RAM is read in the accept cycle. rsp_valid pulses the next cycle; rsp_data is the selected way/word and holds until the next read.
- Write: a byte-masked RAM write in the accept cycle; dirty[line][way] |= byteen << (wsel*WORD_SIZE). A read accepted the following cycle returns the new data.
- Clean fill (mask 0): full-line RAM write in the accept cycle; mask stays 0; no eviction.
- Dirty fill: the accept cycle reads the victim and latches its mask. FILL_CAP captures the RAM data plus line, way and mask into the eviction buffer, writes the fill data, clears the mask, and returns to IDLE. evict_valid rises the cycle after FILL_CAP.
- Eviction buffer: holds its contents stable while evict_valid & ~evict_ready; clears on the handshake.
- Flush: flush_req is sampled in IDLE only when no request is accepted that cycle (requests have priority). Entering FL_SCAN sets flush_busy; req_ready is 0 throughout.
- FL_SCAN walks (line, way) with way fastest, from (0,0) to (LINES-1, NUM_WAYS-1), one entry per cycle. A clean entry advances. A dirty entry goes to FL_RD (RAM read), then FL_CAP (capture into the buffer, clear the mask), then FL_WAIT until the buffer has drained, then resumes the scan.
- If the buffer is occupied on entry to FL_RD, the FSM waits in FL_SCAN.
- After the last entry, once the buffer is empty: flush_done pulses for one cycle, flush_busy drops, and the FSM returns to IDLE.
- way_sel with zero or multiple bits set is illegal and the behaviour is undefined. The bench asserts one-hot on accept.

Test Plan:
- Reset, then read line 3 way 0 -> rsp_valid exactly 1 cycle after accept; evict_valid=0, flush_busy=0.
- Write line 5 way 1 wsel 2 byteen 0b0011 data 0xAABBCCDD; read it back next cycle -> rsp_data low 2 bytes 0xCCDD; internal mask of line 5 way 1 = 0x0300.
- Dirty fill of line 5 way 1 -> evict_valid rises 2 cycles after accept, evict_line=5, evict_way=1, evict_byteen=0x0300, evict_data = old line; a subsequent read returns fill data.
- Evict buffer held with evict_ready=0, then a second dirty fill -> req_ready=0 until the handshake; a clean fill is accepted meanwhile; evict_* stay stable.
- Dirty lines 0 and LINES-1, flush_req with evict_ready=1 -> exactly 2 evictions in ascending order, then one flush_done pulse; a subsequent flush produces no evictions.
- Assert reset during FL_WAIT -> next cycle evict_valid=0 and flush_busy=0; after reset, a flush gives flush_done with zero evictions.
